// File: rtl/tpu_pkg.sv
// Shared TPU types: data word and feeder FSM states.
// Imported by systolic_feeder and feeder_skid.
package tpu_pkg;

  localparam int DATA_WIDTH = 16;

  typedef logic signed [DATA_WIDTH-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/feeder_skid.sv
// Per-row 1-entry skid buffer plus output register for the feeder.
// Ports: clk, rst (sync, active-high), stall, in_valid/in_data (from
// accumulator), out_valid/out_data (to array), empty (skid is free).
// Build option: SYSTOLIC_FEEDER_ZERO_PAD_EN forces out_data to 0 while
// out_valid is low; otherwise out_data holds its last loaded value.
module feeder_skid
  import tpu_pkg::*;
#(
  parameter int W = DATA_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                in_valid,
  input  logic signed [W-1:0] in_data,
  output logic                out_valid,
  output logic signed [W-1:0] out_data,
  output logic                empty
);

  logic                skid_full;
  logic signed [W-1:0] skid_data;
  logic signed [W-1:0] out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_full <= 1'b0;
      skid_data <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (stall) begin
      // Output register holds; a beat already in flight parks here.
      if (in_valid) begin
        skid_full <= 1'b1;
        skid_data <= in_data;
      end
    end else if (skid_full) begin
      // Parked beat is older, so it leaves first.
      out_valid <= 1'b1;
      out_q     <= skid_data;
      skid_full <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out_q <= in_data;
    end
  end

`ifdef SYSTOLIC_FEEDER_ZERO_PAD_EN
  assign out_data = out_valid ? out_q : '0;
`else
  assign out_data = out_q;
`endif

  assign empty = ~skid_full;

  // deq is suppressed while stalled, so a second parked beat is a bug.
  assert property (@(posedge clk) disable iff (rst)
    !(stall && in_valid && skid_full));

endmodule

// File: rtl/systolic_feeder.sv
// Staggered feeder for the systolic array's left edge.
// Issues per-row dequeue strobes as a diagonal wavefront (row r starts
// r cycles after row 0), captures returned accumulator data and drives
// it to the array with valid qualifiers; honours stall via per-row skids.
// Ports: clk, rst (sync, active-high), start_in/len_in (pass command),
// stall_in (array backpressure), deq_out (per-row dequeue),
// acc_valid_in/acc_data_in (accumulator return), sys_valid_out/
// sys_data_out (to array), busy_out, done_out (1-cycle completion).
// Build option: SYSTOLIC_FEEDER_ZERO_PAD_EN zeroes data on invalid beats.
module systolic_feeder #(
  parameter int ROWS       = 2,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_in,
  input  logic [LEN_WIDTH-1:0]       len_in,
  input  logic                       stall_in,
  output logic [ROWS-1:0]            deq_out,
  input  logic [ROWS-1:0]            acc_valid_in,
  input  logic [ROWS*DATA_WIDTH-1:0] acc_data_in,
  output logic [ROWS-1:0]            sys_valid_out,
  output logic [ROWS*DATA_WIDTH-1:0] sys_data_out,
  output logic                       busy_out,
  output logic                       done_out
);

  import tpu_pkg::*;

  // t reaches len_q + ROWS - 2; headroom for ROWS up to 16.
  localparam int TW = LEN_WIDTH + 5;

  feeder_state_t        state;
  logic [TW-1:0]        t;
  logic [LEN_WIDTH-1:0] len_q;
  logic [TW-1:0]        t_last;
  logic [ROWS-1:0]      empty;
  logic [ROWS-1:0]      acc_live;

  assign t_last = TW'(len_q) + TW'(ROWS) - TW'(2);

  // Returns arriving after an abort are dropped, not presented.
  assign acc_live = acc_valid_in & {ROWS{busy_out}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      t        <= '0;
      len_q    <= '0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
    end else begin
      done_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_in && len_in != '0) begin
            len_q    <= len_in;
            t        <= '0;
            busy_out <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (!stall_in) begin
            if (t == t_last) state <= DRAIN;
            else             t     <= t + 1'b1;
          end
        end
        DRAIN: begin
          if (&empty && acc_live == '0 && !stall_in) begin
            busy_out <= 1'b0;
            done_out <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    deq_out = '0;
    for (int r = 0; r < ROWS; r++) begin
      deq_out[r] = (state == RUN) && !stall_in &&
                   (t >= TW'(r)) &&
                   (t < TW'(r) + TW'(len_q));
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    feeder_skid #(
      .W(DATA_WIDTH)
    ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .stall    (stall_in),
      .in_valid (acc_live[r]),
      .in_data  (acc_data_in[r*DATA_WIDTH +: DATA_WIDTH]),
      .out_valid(sys_valid_out[r]),
      .out_data (sys_data_out[r*DATA_WIDTH +: DATA_WIDTH]),
      .empty    (empty[r])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder (ROWS=2, 16-bit data).
// Accumulator model answers deq_out one cycle later from per-row queues.
module tb_systolic_feeder;

  localparam int ROWS = 2;
  localparam int DW   = 16;
  localparam int LW   = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start_in = 1'b0;
  logic [LW-1:0]        len_in = '0;
  logic                 stall_in = 1'b0;
  logic [ROWS-1:0]      deq_out;
  logic [ROWS-1:0]      acc_valid_in = '0;
  logic [ROWS*DW-1:0]   acc_data_in = '0;
  logic [ROWS-1:0]      sys_valid_out;
  logic [ROWS*DW-1:0]   sys_data_out;
  logic                 busy_out;
  logic                 done_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] acc0[$];
  logic [DW-1:0] acc1[$];
  logic [DW-1:0] exp0[$];
  logic [DW-1:0] exp1[$];

  systolic_feeder #(
    .ROWS(ROWS),
    .DATA_WIDTH(DW),
    .LEN_WIDTH(LW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_in     (start_in),
    .len_in       (len_in),
    .stall_in     (stall_in),
    .deq_out      (deq_out),
    .acc_valid_in (acc_valid_in),
    .acc_data_in  (acc_data_in),
    .sys_valid_out(sys_valid_out),
    .sys_data_out (sys_data_out),
    .busy_out     (busy_out),
    .done_out     (done_out)
  );

  always #5 clk = ~clk;

  // Accumulator model: 1-cycle dequeue latency.
  always @(posedge clk) begin
    acc_valid_in <= '0;
    if (deq_out[0] && acc0.size() > 0) begin
      acc_valid_in[0]   <= 1'b1;
      acc_data_in[DW-1:0] <= acc0.pop_front();
    end
    if (deq_out[1] && acc1.size() > 0) begin
      acc_valid_in[1]        <= 1'b1;
      acc_data_in[2*DW-1:DW] <= acc1.pop_front();
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic beat(input int r, input logic [DW-1:0] got);
    logic [DW-1:0] want;
    n_cmp++;
    if ((r == 0 && exp0.size() == 0) || (r == 1 && exp1.size() == 0)) begin
      n_bad++;
      $display("FAIL beat_row%0d: got %h want no beat", r, got);
    end else begin
      want = (r == 0) ? exp0.pop_front() : exp1.pop_front();
      if (got !== want) begin
        n_bad++;
        $display("FAIL beat_row%0d: got %h want %h", r, got, want);
      end
    end
  endtask

  // Monitor: a beat is taken by the array when valid and not stalled.
  always @(negedge clk) begin
    #2;
    if (!stall_in) begin
      if (sys_valid_out[0]) beat(0, sys_data_out[DW-1:0]);
      if (sys_valid_out[1]) beat(1, sys_data_out[2*DW-1:DW]);
    end
  end

  // Drive one pass cycle by cycle; bit i of each mask is cycle i.
  task automatic run_pass(
    input  int          len,
    input  int          ncyc,
    input  int          probe,
    input  logic [31:0] stall_m,
    input  logic [31:0] start_m,
    input  logic [31:0] rst_m,
    output logic [31:0] d0,
    output logic [31:0] d1,
    output logic [31:0] bz,
    output logic [31:0] dn,
    output logic [31:0] v0,
    output logic [31:0] v1,
    output logic [31:0] pd,
    output logic [31:0] ed
  );
    d0 = '0; d1 = '0; bz = '0; dn = '0; v0 = '0; v1 = '0; pd = '0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      start_in = start_m[i];
      len_in   = (i == 0) ? LW'(len) : LW'(7);
      stall_in = stall_m[i];
      rst      = rst_m[i];
      #1;
      d0[i] = deq_out[0];
      d1[i] = deq_out[1];
      bz[i] = busy_out;
      dn[i] = done_out;
      v0[i] = sys_valid_out[0];
      v1[i] = sys_valid_out[1];
      if (i == probe) pd = sys_data_out;
    end
    ed = sys_data_out;
    @(negedge clk);
    start_in = 1'b0;
    stall_in = 1'b0;
    rst      = 1'b0;
    #3;
    check("left_row0", exp0.size(), 0);
    check("left_row1", exp1.size(), 0);
  endtask

  logic [31:0] d0, d1, bz, dn, v0, v1, pd, ed;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_deq", 32'(deq_out), 0);
    check("rst_valid", 32'(sys_valid_out), 0);
    check("rst_data", sys_data_out, 0);
    check("rst_busy", 32'(busy_out), 0);
    check("rst_done", 32'(done_out), 0);

    // Basic wavefront, len 3.
    acc0 = '{16'd1, 16'd2, 16'd3};
    acc1 = '{16'd10, 16'd20, 16'd30};
    exp0 = '{16'd1, 16'd2, 16'd3};
    exp1 = '{16'd10, 16'd20, 16'd30};
    run_pass(3, 12, 3, 32'h0, 32'h1, 32'h0, d0, d1, bz, dn, v0, v1, pd, ed);
    check("basic_deq0", d0, 32'h0E);
    check("basic_deq1", d1, 32'h1C);
    check("basic_busy", bz, 32'h7E);
    check("basic_done", dn, 32'h80);
    check("basic_v0", v0, 32'h38);
    check("basic_v1", v1, 32'h70);
    check("basic_row1_c3", 32'(pd[31:16]), 0);
`ifdef SYSTOLIC_FEEDER_ZERO_PAD_EN
    check("basic_row1_end", 32'(ed[31:16]), 0);
`else
    check("basic_row1_end", 32'(ed[31:16]), 30);
`endif

    // Stall in cycles 3-4.
    acc0 = '{16'd1, 16'd2, 16'd3};
    acc1 = '{16'd10, 16'd20, 16'd30};
    exp0 = '{16'd1, 16'd2, 16'd3};
    exp1 = '{16'd10, 16'd20, 16'd30};
    run_pass(3, 12, 4, 32'h18, 32'h1, 32'h0, d0, d1, bz, dn, v0, v1, pd, ed);
    check("stall_deq0", d0, 32'h26);
    check("stall_deq1", d1, 32'h64);
    check("stall_busy", bz, 32'h1FE);
    check("stall_done", dn, 32'h200);
    check("stall_v0", v0, 32'hF8);
    check("stall_v1", v1, 32'h1C0);
    check("stall_row0_frozen", 32'(pd[15:0]), 1);

    // len_in = 0 is ignored.
    run_pass(0, 6, 0, 32'h0, 32'h1, 32'h0, d0, d1, bz, dn, v0, v1, pd, ed);
    check("len0_deq", d0 | d1, 0);
    check("len0_busy", bz, 0);
    check("len0_done", dn, 0);

    // Starts during RUN and DONE are ignored.
    acc0 = '{16'd4, 16'd5, 16'd6, 16'd7};
    acc1 = '{16'd40, 16'd50, 16'd60, 16'd70};
    exp0 = '{16'd4, 16'd5, 16'd6};
    exp1 = '{16'd40, 16'd50, 16'd60};
    run_pass(3, 12, 0, 32'h0, 32'h8D, 32'h0, d0, d1, bz, dn, v0, v1, pd, ed);
    check("gate_deq0", d0, 32'h0E);
    check("gate_deq1", d1, 32'h1C);
    check("gate_busy", bz, 32'h7E);
    check("gate_done", dn, 32'h80);
    acc0.delete();
    acc1.delete();

    // Reset in cycle 4 of a len-5 pass.
    acc0 = '{16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
    acc1 = '{16'd50, 16'd60, 16'd70, 16'd80, 16'd90};
    exp0 = '{16'd5, 16'd6};
    exp1 = '{16'd50};
    run_pass(5, 12, 5, 32'h0, 32'h1, 32'h10, d0, d1, bz, dn, v0, v1, pd, ed);
    check("rstmid_deq0", d0, 32'h1E);
    check("rstmid_deq1", d1, 32'h1C);
    check("rstmid_busy", bz, 32'h1E);
    check("rstmid_done", dn, 0);
    check("rstmid_v0", v0, 32'h18);
    check("rstmid_v1", v1, 32'h10);
    check("rstmid_data_c5", pd, 0);
    acc0.delete();
    acc1.delete();

    // Fresh pass with signed extremes.
    acc0 = '{16'h8000, 16'h7FFF};
    acc1 = '{16'h7FFF, 16'h8000};
    exp0 = '{16'h8000, 16'h7FFF};
    exp1 = '{16'h7FFF, 16'h8000};
    run_pass(2, 10, 0, 32'h0, 32'h1, 32'h0, d0, d1, bz, dn, v0, v1, pd, ed);
    check("sign_deq0", d0, 32'h06);
    check("sign_deq1", d1, 32'h0C);
    check("sign_busy", bz, 32'h3E);
    check("sign_done", dn, 32'h40);
    check("sign_v0", v0, 32'h18);
    check("sign_v1", v1, 32'h30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Sits between the per-row input accumulators and the left edge of the systolic array.
- On a start command it issues staggered dequeue strobes so that row r begins r cycles after row 0, forming the diagonal wavefront. It captures the data each accumulator returns and presents it to the array with valid qualifiers.
- Honours array backpressure using a 1-entry skid per row and signals completion.

Parameters:
- ROWS, 2, number of array rows and accumulators (1..16)
- DATA_WIDTH, 16, signed fixed-point word width
- LEN_WIDTH, 8, width of the vector-length field

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start_in  in  1  begin a feed pass; sampled only in IDLE
- len_in  in  LEN_WIDTH  vectors per row for this pass; sampled with start_in
- stall_in  in  1  array cannot accept a beat this cycle
- deq_out  out  ROWS  per-row dequeue strobe; drives each accumulator's valid_in
- acc_valid_in  in  ROWS  per-row returned-data valid, 1 cycle after deq_out
- acc_data_in  in  ROWS*DATA_WIDTH  per-row returned data, signed
- sys_valid_out  out  ROWS  per-row beat valid to the array
- sys_data_out  out  ROWS*DATA_WIDTH  per-row data to the array
- busy_out  out  1  pass in progress
- done_out  out  1  one-cycle pulse at pass completion

Behaviour:
- Reset: FSM=IDLE; t=0; len_q=0; all skids empty; sys_valid_out=0; sys_data_out=0; busy_out=0; done_out=0. deq_out=0 follows from IDLE.
- Reset mid-pass: abort immediately, same values. Accumulator contents are not touched.
- FSM states:
  - IDLE: start_in=1 and len_in!=0 latches len_q and moves to RUN next cycle. len_in=0 is ignored and stays IDLE. start_in in any other state is ignored.
  - RUN: t counts 0..len_q+ROWS-2 and advances only when stall_in=0. deq_out[r] = (r <= t < r+len_q) & ~stall_in, combinational from registered t. On the last t with stall_in=0, move to DRAIN.
  - DRAIN: wait until every skid is empty and no acc_valid_in is in flight, then one more unstalled cycle to emit the final beat. Then move to DONE.
  - DONE: done_out=1 for exactly one cycle, busy_out=0; return to IDLE. A start_in in this cycle is ignored.
- busy_out = 1 in RUN and DRAIN only.
- Latency: deq_out → acc_valid_in is 1 cycle (accumulator). acc_valid_in → sys_valid_out is 1 cycle (output register). deq to array is therefore 2 cycles.
- Per-row output path:
  - stall_in=0: output register loads the skid if it is full (skid empties), else loads acc_valid_in/acc_data_in.
  - stall_in=1: output register holds. An arriving acc_valid_in beat is written into the skid.
  - The skid never overflows because deq_out is suppressed while stalled.
  - An arrival with the skid already full and stall_in=1 is an assertion failure.
- Data passes through unmodified: signed, no width change.
- If acc_valid_in is low when a beat is expected (accumulator empty), a bubble propagates. The feeder does not retry. It flags nothing unless the optional feature is enabled.

Optional Feature:
- Macro: SYSTOLIC_FEEDER_ZERO_PAD_EN.
- With the macro: whenever sys_valid_out[r]=0, sys_data_out[r] is forced to 0, so the array sees clean zeros in the wavefront triangles and on bubbles.
- Without the macro: sys_data_out[r] holds its last loaded value when invalid.
- Valid timing is identical in both builds.

Decomposition:
- Shared package tpu_pkg holds:
  - DATA_WIDTH localparam and data_t (logic signed [DATA_WIDTH-1:0]).
  - feeder_state_t enum {IDLE, RUN, DRAIN, DONE}.
- One sub-module, feeder_skid: per-row 1-entry skid plus output register, with ports clk, rst, stall, in_valid, in_data, out_valid, out_data, empty. It is instantiated ROWS times in a generate loop.
- The top holds the FSM, the t counter and the deq window compare.

Test Plan:
- Basic wavefront: ROWS=2, start at cycle 0 with len_in=3, no stall, accumulator model returning row0 {1,2,3} and row1 {10,20,30} → expected:
  - deq_out[0] high cycles 1-3; deq_out[1] high cycles 2-4.
  - sys row0 1,2,3 in cycles 3-5; row1 10,20,30 in cycles 4-6.
  - done_out pulse in cycle 7; busy_out high cycles 1-6.
- Stall mid-pass: same setup with stall_in high cycles 3-4 →
  - deq_out all 0 in cycles 3-4; row outputs frozen.
  - The in-flight beat lands in the skid and emerges first after release.
  - Ordering is preserved: row0 1,2,3 and row1 10,20,30, with no loss or duplication.
  - done_out is delayed by exactly 2 cycles.
- Start gating:
  - start_in with len_in=0 → stays IDLE, no deq_out.
  - start_in pulsed during RUN → ignored; pass length unchanged.
- Reset mid-pass: rst at cycle 4 of a len=5 pass → next cycle:
  - All outputs 0, state IDLE, no done_out.
  - A fresh start then runs normally.
- Signed extremes: data 0x8000 and 0x7FFF through both rows → bit-exact at sys_data_out.
- Zero pad: with SYSTOLIC_FEEDER_ZERO_PAD_EN, row1 sys_data_out is 0 in cycle 3 (before its wave arrives). Without the macro it holds the reset value 0, then the held last value after the pass ends (30).
